spi_master_engine: RTL and testbench
====================================

SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 Parameter CLK_DIV, 2, SCLK half-period in clk cycles; legal values are 1 and above.
REQ-002 Parameter DATA_W, 8, frame width in bits.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: the block is reset while reset=0 at a clk rising edge.
REQ-005 masterCPOL  input  1  clock polarity; sampled at transfer start.
REQ-006 masterCPHA  input  1  clock phase; sampled at transfer start.
REQ-007 start  input  1  transfer request; single-cycle or level.
REQ-008 In_Data  input  DATA_W  word to transmit on MOSI; sampled at transfer start.
REQ-009 masterMISO  input  1  serial data from the slave.
REQ-010 masterSCLK  output  1  SPI serial clock.
REQ-011 masterMOSI  output  1  serial data to the slave.
REQ-012 masterCS_  output  1  active-low chip select.
REQ-013 read_data  output  DATA_W  last completed received word.
REQ-014 busy  output  1  high from LEAD through DONE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The state machine SHALL have states IDLE, LEAD, XFER, TRAIL and DONE.
REQ-017 IDLE behaviour: masterCS_=1, masterMOSI=0, busy=0; masterSCLK follows masterCPOL (registered) each cycle.
REQ-018 start=1 in IDLE: latch In_Data, masterCPOL and masterCPHA; enter LEAD; masterCS_=0 from the next cycle.
REQ-019 start outside IDLE SHALL be ignored; changes to mode inputs or In_Data during a transfer SHALL be ignored.
REQ-020 LEAD SHALL last CLK_DIV cycles with masterSCLK=CPOL; for CPHA=0, masterMOSI SHALL carry bit 0 during LEAD.
REQ-021 XFER SHALL last 2*DATA_W*CLK_DIV cycles, toggling masterSCLK every CLK_DIV cycles (DATA_W leading and DATA_W trailing edges).
REQ-022 Bit order SHALL be LSB first on both MOSI and MISO.
REQ-023 CPHA=0: sample MISO on each leading edge; shift the next MOSI bit on each trailing edge.
REQ-024 CPHA=1: shift a MOSI bit on each leading edge (bit 0 on the first); sample MISO on each trailing edge.
REQ-025 TRAIL SHALL last CLK_DIV cycles with masterSCLK=CPOL and masterCS_=0.
REQ-026 DONE SHALL last 1 cycle with masterCS_=1, done=1, and read_data loaded with the captured word; the next state is IDLE.
REQ-027 done SHALL assert exactly (2*DATA_W+2)*CLK_DIV+1 cycles after the clk edge that samples start (default 37).
REQ-028 read_data SHALL hold its value until the next DONE state.
REQ-029 start=1 during DONE SHALL be ignored; back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-030 With CLK_DIV=1, masterSCLK SHALL toggle every cycle with no lost bits.

Reset
REQ-031 Reset state: IDLE, masterCS_=1, masterSCLK=0, masterMOSI=0, busy=0, done=0, read_data=0, shift registers and counters=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer on that edge, with no done pulse and read_data cleared.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum, a 2-bit spi_mode_t {CPOL,CPHA} typedef, and the default constants for CLK_DIV and DATA_W.
REQ-034 Sub-module spi_clk_gen SHALL hold the half-period counter and issue lead_edge/trail_edge strobes and SCLK toggling while enabled.

Verification
REQ-035 Mode 0, In_Data=8'h0F, slave returns 8'hAA -> MOSI bits 1,1,1,1,0,0,0,0; read_data=8'hAA; done 37 cycles after start.
REQ-036 Mode 1, In_Data=8'hD8, slave returns 8'h76 -> first MOSI change on the first rising SCLK edge; read_data=8'h76.
REQ-037 Modes 2 and 3, In_Data=8'h59 and 8'h1B -> SCLK idles high, exactly 8 falling-then-rising pulses, correct LSB-first data.
REQ-038 Reset=0 at cycle 10 of a mode 0 transfer -> masterCS_=1 on the next edge, no done pulse, read_data=0.
REQ-039 start held high through a transfer, then DATA_W=8 with CLK_DIV=1 -> one transfer only per start acceptance; done 19 cycles after start.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and default sizing for the SPI master engine
package spi_pkg;

  localparam int SPI_CLK_DIV_DEF = 2;
  localparam int SPI_DATA_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period divider with leading/trailing edge strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic idle_level,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          strobe;

  // The first enabled cycle toggles SCLK, so each half period starts with an edge.
  always_comb begin
    strobe     = en && (cnt_q == '0);
    cnt_d      = '0;
    if (en) begin
      cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
    sclk_d     = en ? (sclk_q ^ strobe) : idle_level;
    lead_edge  = strobe && (sclk_q == idle_level);
    trail_edge = strobe && (sclk_q != idle_level);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - single-frame SPI master, all four modes, LSB first
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int DATA_W  = SPI_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              masterCPOL,
  input  logic              masterCPHA,
  input  logic              start,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              masterMISO,
  output logic              masterSCLK,
  output logic              masterMOSI,
  output logic              masterCS_,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done
);

  localparam int XFER_LEN = 2 * DATA_W * CLK_DIV;
  localparam int CNT_W    = $clog2(XFER_LEN + 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, last_half;
  logic              lead_edge, trail_edge, sclk;
  logic              gen_en, gen_idle;

  assign gen_en   = (state_q == ST_XFER);
  assign gen_idle = (state_q == ST_IDLE) ? masterCPOL : mode_q.cpol;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (gen_en),
    .idle_level(gen_idle),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sclk      (sclk)
  );

  // done_q marks the visible DONE cycle, so a held start cannot chain transfers without an IDLE gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    mode_d    = mode_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    mosi_d    = mosi_q;
    accept    = (state_q == ST_IDLE) && start && !done_q;
    last_half = (cnt_q == CNT_W'(CLK_DIV - 1));

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        mosi_d = 1'b0;
        if (accept) begin
          state_d     = ST_LEAD;
          mode_d.cpol = masterCPOL;
          mode_d.cpha = masterCPHA;
          tx_d        = In_Data;
          rx_d        = '0;
        end
      end
      ST_LEAD: begin
        if (!mode_q.cpha) mosi_d = tx_q[0];
        if (last_half) begin
          state_d = ST_XFER;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        if (lead_edge) begin
          if (mode_q.cpha) begin
            mosi_d = tx_q[0];
            tx_d   = tx_q >> 1;
          end else begin
            rx_d = {masterMISO, rx_q[DATA_W-1:1]};
          end
        end
        if (trail_edge) begin
          if (mode_q.cpha) begin
            rx_d = {masterMISO, rx_q[DATA_W-1:1]};
          end else begin
            tx_d   = tx_q >> 1;
            mosi_d = tx_d[0];
          end
        end
        if (cnt_q == CNT_W'(XFER_LEN - 1)) begin
          state_d = ST_TRAIL;
          cnt_d   = '0;
        end
      end
      ST_TRAIL: begin
        if (last_half) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        mosi_d  = 1'b0;
        rd_d    = rx_q;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    cs_d   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign masterSCLK = sclk;
  assign masterMOSI = mosi_q;
  assign masterCS_  = cs_q;
  assign read_data  = rd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed bench for spi_master_engine at CLK_DIV 2 and 1
module tb_spi_master_engine;

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, start0, start1, miso0, miso1;
  logic [7:0] in_data;
  logic       sclk0, mosi0, cs0, busy0, done0;
  logic       sclk1, mosi1, cs1, busy1, done1;
  logic [7:0] rd0, rd1;

  always #5 clk = ~clk;

  spi_master_engine #(.CLK_DIV(2), .DATA_W(8)) dut0 (
    .clk(clk), .reset(reset), .masterCPOL(cpol), .masterCPHA(cpha), .start(start0),
    .In_Data(in_data), .masterMISO(miso0), .masterSCLK(sclk0), .masterMOSI(mosi0),
    .masterCS_(cs0), .read_data(rd0), .busy(busy0), .done(done0)
  );

  spi_master_engine #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset), .masterCPOL(cpol), .masterCPHA(cpha), .start(start1),
    .In_Data(in_data), .masterMISO(miso1), .masterSCLK(sclk1), .masterMOSI(mosi1),
    .masterCS_(cs1), .read_data(rd1), .busy(busy1), .done(done1)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         lat;
  int         cs_low;
  logic       s_cpol, s_cpha;
  logic [7:0] sb [2];
  logic [7:0] cap [2];
  int         idx [2];
  int         edges [2];
  int         leads [2];
  int         dn [2];
  int         done_at [2];
  logic       cs_prev [2];
  logic       sclk_prev [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: drives its word LSB first and captures MOSI on its own sample edge.
  task automatic slave_step(input int s, input logic sclk, input logic cs, input logic mosi);
    logic b;
    b = (s == 0) ? miso0 : miso1;
    if (cs_prev[s] && !cs) begin
      idx[s] = 0; cap[s] = '0; edges[s] = 0; leads[s] = 0;
      if (!s_cpha) begin
        b = sb[s][0];
        idx[s] = 1;
      end
    end else if (!cs && (sclk != sclk_prev[s])) begin
      edges[s]++;
      if (sclk != s_cpol) begin
        leads[s]++;
        if (!s_cpha) cap[s] = {mosi, cap[s][7:1]};
        else begin
          b = (idx[s] < 8) ? sb[s][idx[s]] : 1'b0;
          idx[s]++;
        end
      end else begin
        if (s_cpha) cap[s] = {mosi, cap[s][7:1]};
        else begin
          b = (idx[s] < 8) ? sb[s][idx[s]] : 1'b0;
          idx[s]++;
        end
      end
    end
    cs_prev[s]   = cs;
    sclk_prev[s] = sclk;
    if (s == 0) miso0 = b;
    else        miso1 = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    slave_step(0, sclk0, cs0, mosi0);
    slave_step(1, sclk1, cs1, mosi1);
    if (done0) begin dn[0]++; done_at[0] = cyc; end
    if (done1) begin dn[1]++; done_at[1] = cyc; end
  endtask

  task automatic xfer(input int s, input logic [7:0] data, input logic [7:0] sbits,
                      input bit hold, input bit perturb, output int latency);
    int c0;
    in_data = data;
    sb[s]   = sbits;
    dn[s]   = 0;
    if (s == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    c0 = cyc;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    if (perturb) begin cpol = ~cpol; cpha = ~cpha; in_data = ~data; end
    for (int i = 0; i < 100 && dn[s] == 0; i++) begin
      tick();
      if (i == 0) check("lead_mosi", 32'((s == 0) ? mosi0 : mosi1), 32'(s_cpha ? 1'b0 : data[0]));
      if (i == 2) check("busy_mid", 32'((s == 0) ? busy0 : busy1), 32'(1));
      if (i == 2) check("cs_low_mid", 32'((s == 0) ? cs0 : cs1), 32'(0));
    end
    latency = (dn[s] != 0) ? done_at[s] - c0 : -1;
    check("cs_at_done", 32'((s == 0) ? cs0 : cs1), 32'(1));
    tick();
    check("done_width", 32'((s == 0) ? done0 : done1), 32'(0));
    check("busy_after", 32'((s == 0) ? busy0 : busy1), 32'(0));
    if (perturb) begin cpol = s_cpol; cpha = s_cpha; end
  endtask

  initial begin
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; cpol = 1'b0; cpha = 1'b0;
    in_data = 8'h00; miso0 = 1'b0; miso1 = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sb[s] = '0; cap[s] = '0; idx[s] = 0; edges[s] = 0; leads[s] = 0;
      dn[s] = 0; done_at[s] = 0; cs_prev[s] = 1'b1; sclk_prev[s] = 1'b0;
    end
    repeat (3) tick();
    check("rst_cs", 32'(cs0), 32'(1));
    check("rst_sclk", 32'(sclk0), 32'(0));
    check("rst_mosi", 32'(mosi0), 32'(0));
    check("rst_busy", 32'(busy0), 32'(0));
    check("rst_done", 32'(done0), 32'(0));
    check("rst_rd", 32'(rd0), 32'(0));
    reset = 1'b1;
    repeat (2) tick();

    // mode 0
    xfer(0, 8'h0F, 8'hAA, 1'b0, 1'b0, lat);
    check("m0_latency", 32'(lat), 32'(37));
    check("m0_rd", 32'(rd0), 32'(8'hAA));
    check("m0_mosi", 32'(cap[0]), 32'(8'h0F));
    check("m0_edges", 32'(edges[0]), 32'(16));

    // mode 1 with mode and data inputs disturbed mid-transfer
    cpol = 1'b0; cpha = 1'b1; s_cpol = 1'b0; s_cpha = 1'b1;
    repeat (2) tick();
    xfer(0, 8'hD8, 8'h76, 1'b0, 1'b1, lat);
    check("m1_latency", 32'(lat), 32'(37));
    check("m1_rd", 32'(rd0), 32'(8'h76));
    check("m1_mosi", 32'(cap[0]), 32'(8'hD8));
    check("m1_leads", 32'(leads[0]), 32'(8));

    // mode 2
    cpol = 1'b1; cpha = 1'b0; s_cpol = 1'b1; s_cpha = 1'b0;
    repeat (3) tick();
    check("m2_idle_sclk", 32'(sclk0), 32'(1));
    xfer(0, 8'h59, 8'h3C, 1'b0, 1'b0, lat);
    check("m2_rd", 32'(rd0), 32'(8'h3C));
    check("m2_mosi", 32'(cap[0]), 32'(8'h59));
    check("m2_falls", 32'(leads[0]), 32'(8));
    check("m2_edges", 32'(edges[0]), 32'(16));
    check("m2_sclk_end", 32'(sclk0), 32'(1));

    // mode 3
    cpol = 1'b1; cpha = 1'b1; s_cpol = 1'b1; s_cpha = 1'b1;
    repeat (3) tick();
    xfer(0, 8'h1B, 8'hC5, 1'b0, 1'b0, lat);
    check("m3_rd", 32'(rd0), 32'(8'hC5));
    check("m3_mosi", 32'(cap[0]), 32'(8'h1B));
    check("m3_edges", 32'(edges[0]), 32'(16));
    check("m3_sclk_end", 32'(sclk0), 32'(1));

    // start held through a transfer and its DONE cycle
    cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
    repeat (3) tick();
    xfer(0, 8'h96, 8'h5A, 1'b1, 1'b0, lat);
    start0 = 1'b0;
    check("hold_latency", 32'(lat), 32'(37));
    check("hold_rd", 32'(rd0), 32'(8'h5A));
    cs_low = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!cs0) cs_low++;
    end
    check("hold_one_done", 32'(dn[0]), 32'(1));
    check("hold_no_restart", 32'(cs_low), 32'(0));

    // reset abort at cycle 10 of a mode 0 transfer
    in_data = 8'hE7; sb[0] = 8'h81; dn[0] = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    tick();
    check("abort_cs", 32'(cs0), 32'(1));
    check("abort_rd", 32'(rd0), 32'(0));
    check("abort_busy", 32'(busy0), 32'(0));
    reset = 1'b1;
    repeat (50) tick();
    check("abort_no_done", 32'(dn[0]), 32'(0));

    // CLK_DIV = 1 with start held
    xfer(1, 8'hA5, 8'h3C, 1'b1, 1'b0, lat);
    start1 = 1'b0;
    check("div1_latency", 32'(lat), 32'(19));
    check("div1_rd", 32'(rd1), 32'(8'h3C));
    check("div1_mosi", 32'(cap[1]), 32'(8'hA5));
    check("div1_edges", 32'(edges[1]), 32'(16));
    repeat (30) tick();
    check("div1_one_done", 32'(dn[1]), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
